// File: rtl/mux_pkg.sv
// Shared types and defaults for the round-robin output mux arbiter.
package mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DATA_W  = 9;
  localparam int NUM_REQ = 4;

endpackage

// File: rtl/button_debounce.sv
// Button synchronizer, debounce filter and rising-edge pulse.
module button_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise_p
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // The counter only advances while the synced level disagrees with the accepted one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      rise_p <= 1'b0;
    end else begin
      sync1  <= btn_in;
      sync2  <= sync1;
      rise_p <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        level  <= sync2;
        rise_p <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing the registered output mux among requesters,
// with hold-limited tenures and a debounced manual handover button.
module mux_arbiter
  import mux_pkg::*;
#(
  parameter int DATA_W   = mux_pkg::DATA_W,
  parameter int NUM_REQ  = mux_pkg::NUM_REQ,
  parameter int MAX_HOLD = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] dataIn,
  input  logic                      toggleButton,
  output logic [NUM_REQ-1:0]        grant,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic [DATA_W-1:0]         dataOut,
  output logic                      dataValid
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [HOLD_W-1:0]  holdCnt;
  logic               btnLevel;
  logic               btnRise;
  logic               togglePulse;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   nextPtr;
  logic [DATA_W-1:0]  ownerData;
  logic               reqOwner;
  logic               others;
  logic               holdMax;
  logic               exitGrant;

  function automatic logic [IDX_W-1:0] rrPick(
    input logic [NUM_REQ-1:0] r,
    input logic [IDX_W-1:0]   p
  );
    logic [IDX_W-1:0] w;
    logic             found;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (int'(p) + i) % NUM_REQ;
      if (!found && r[k]) begin
        w     = IDX_W'(k);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  button_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) uDebounce (
    .clk   (clk),
    .rst   (rst),
    .btn_in(toggleButton),
    .level (btnLevel),
    .rise_p(btnRise)
  );

  assign togglePulse = btnRise & btnLevel;
  assign winner      = rrPick(req, ptr);
  assign nextPtr     = IDX_W'((int'(owner) + 1) % NUM_REQ);
  assign ownerData   = dataIn[int'(owner)*DATA_W +: DATA_W];
  assign reqOwner    = req[owner];
  // grant is one-hot on the owner while in GRANT
  assign others      = |(req & ~grant);
  assign holdMax     = (holdCnt == HOLD_LAST);
  assign exitGrant   = !reqOwner | (others & (holdMax | togglePulse));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      owner     <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      ptr       <= '0;
      holdCnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_GAP: begin
          dataValid <= 1'b0;
          if (|req) begin
            state   <= ST_GRANT;
            grant   <= NUM_REQ'(1) << winner;
            owner   <= winner;
            holdCnt <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (reqOwner) begin
            dataOut <= ownerData;
            if (!holdMax) holdCnt <= holdCnt + 1'b1;
          end
          if (exitGrant) begin
            state     <= ST_GAP;
            ptr       <= nextPtr;
            grant     <= '0;
            dataValid <= 1'b0;
          end else begin
            dataValid <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          grant     <= '0;
          dataValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Randomized scoreboard bench for mux_arbiter against a behavioural model.
module tb_mux_arbiter;

  localparam int DW  = 9;
  localparam int NR  = 4;
  localparam int MH  = 8;
  localparam int DEB = 4;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  dataIn;
  logic              toggleButton;
  logic [NR-1:0]     grant;
  logic [1:0]        owner;
  logic [DW-1:0]     dataOut;
  logic              dataValid;

  typedef struct {
    logic [NR-1:0] g;
    logic [1:0]    o;
    logic [DW-1:0] d;
    logic          v;
  } exp_t;

  exp_t expQ[$];
  int   nChecks;
  int   nPass;

  // reference model state: phase 0=idle, 1=granted, 2=gap
  int        mPhase;
  int        mOwner;
  int        mPtr;
  int        mHold;
  logic [DW-1:0] mData;
  logic      mValid;
  logic      mLevel;
  logic      mTog;
  logic      rawHist[$];
  logic      s2Hist[$];

  mux_arbiter #(
    .DATA_W  (DW),
    .NUM_REQ (NR),
    .MAX_HOLD(MH),
    .DEBOUNCE(DEB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .dataIn      (dataIn),
    .toggleButton(toggleButton),
    .grant       (grant),
    .owner       (owner),
    .dataOut     (dataOut),
    .dataValid   (dataValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] slot(input int i);
    return dataIn[i*DW +: DW];
  endfunction

  task automatic check1(input string name, input int act, input int want);
    nChecks++;
    if (act == want) nPass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, want);
  endtask

  // Behavioural reference: one step per rising edge.
  initial begin
    mPhase = 0; mOwner = 0; mPtr = 0; mHold = 0;
    mData = '0; mValid = 1'b0; mLevel = 1'b0; mTog = 1'b0;
    forever begin
      exp_t e;
      @(posedge clk);
      if (!rst) begin
        mPhase = 0; mOwner = 0; mPtr = 0; mHold = 0;
        mData = '0; mValid = 1'b0; mLevel = 1'b0; mTog = 1'b0;
        rawHist.delete();
        s2Hist.delete();
      end else begin
        logic s2;
        logic newTog;
        logic allDiff;
        bit   pend;
        pend = 0;
        for (int i = 0; i < NR; i++)
          if (i != mOwner && req[i]) pend = 1;
        if (mPhase != 1) begin
          mValid = 1'b0;
          if (req != 0) begin
            for (int i = NR - 1; i >= 0; i--)
              if (req[(mPtr + i) % NR]) mOwner = (mPtr + i) % NR;
            mPhase = 1;
            mHold  = 0;
          end else begin
            mPhase = 0;
          end
        end else begin
          bit leave;
          leave = !req[mOwner] || (pend && (mHold == MH - 1 || mTog));
          if (req[mOwner]) begin
            mData = slot(mOwner);
            if (mHold < MH - 1) mHold++;
          end
          if (leave) begin
            mPhase = 2;
            mPtr   = (mOwner + 1) % NR;
            mValid = 1'b0;
          end else begin
            mValid = 1'b1;
          end
        end
        rawHist.push_back(toggleButton);
        if (rawHist.size() > 3) void'(rawHist.pop_front());
        s2 = (rawHist.size() == 3) ? rawHist[0] : 1'b0;
        s2Hist.push_back(s2);
        if (s2Hist.size() > DEB) void'(s2Hist.pop_front());
        newTog  = 1'b0;
        allDiff = (s2Hist.size() == DEB);
        foreach (s2Hist[k]) if (s2Hist[k] == mLevel) allDiff = 1'b0;
        if (allDiff) begin
          mLevel = ~mLevel;
          newTog = mLevel;
          s2Hist.delete();
        end
        mTog = newTog;
      end
      e.g = (mPhase == 1) ? NR'(1) << mOwner : '0;
      e.o = 2'(mOwner);
      e.d = mData;
      e.v = mValid;
      expQ.push_back(e);
    end
  end

  // Monitor: compare DUT outputs against queued expectations.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      nChecks++;
      if (expQ.size() == 0) begin
        $display("FAIL scoreboard: no expectation queued at %0t", $time);
      end else begin
        e = expQ.pop_front();
        if (grant === e.g && owner === e.o && dataOut === e.d && dataValid === e.v)
          nPass++;
        else
          $display("FAIL cycle@%0t: got g=%b o=%0d d=%0d v=%b, want g=%b o=%0d d=%0d v=%b",
                   $time, grant, owner, dataOut, dataValid, e.g, e.o, e.d, e.v);
      end
    end
  end

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitOwner(input int o);
    bit hit;
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (mPhase == 1 && mOwner == o) hit = 1;
    end
    check1("waitOwner", hit ? o : -1, o);
  endtask

  task automatic setData(input int mult);
    for (int i = 0; i < NR; i++) dataIn[i*DW +: DW] = DW'(mult * (i + 1));
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    rst = 1'b0;
    req = 4'b1111;
    toggleButton = 1'b0;
    dataIn = '0;
    setData(10);
    runCycles(2);
    check1("rstGrant", int'(grant), 0);
    check1("rstData", int'(dataOut), 0);
    check1("rstValid", int'(dataValid), 0);
    check1("rstOwner", int'(owner), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check1("firstGrant", int'(grant), 1);
    runCycles(4);

    req = 4'b0100;
    dataIn[2*DW +: DW] = DW'(20);
    runCycles(30);
    check1("singleHeld", int'(grant), 4);
    check1("singleData", int'(dataOut), 20);

    setData(10);
    req = 4'b1111;
    runCycles(45);

    req = 4'b0011;
    waitOwner(0);
    runCycles(2);
    req = 4'b0010;
    runCycles(6);

    req = 4'b0011;
    waitOwner(0);
    toggleButton = 1'b1;
    runCycles(10);
    toggleButton = 1'b0;
    runCycles(12);
    waitOwner(0);
    toggleButton = 1'b1;
    runCycles(2);
    toggleButton = 1'b0;
    runCycles(12);
    req = 4'b0001;
    runCycles(3);
    toggleButton = 1'b1;
    runCycles(10);
    toggleButton = 1'b0;
    runCycles(10);
    check1("soloToggle", int'(grant), 1);

    req = 4'b0100;
    setData(7);
    waitOwner(2);
    runCycles(3);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check1("asyncGrant", int'(grant), 0);
    check1("asyncOwner", int'(owner), 0);
    check1("asyncData", int'(dataOut), 0);
    check1("asyncValid", int'(dataValid), 0);
    @(negedge clk);
    req = 4'b0101;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check1("postRstGrant", int'(grant), 1);
    runCycles(5);

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) req = NR'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++) dataIn[i*DW +: DW] = DW'($urandom);
      if ($urandom_range(0, 11) == 0) toggleButton = ~toggleButton;
    end
    runCycles(3);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter that shares the 9-bit sequential output mux between `NUM_REQ` requesters. Each requester raises a request and presents its data. The arbiter grants one requester at a time, registers that requester's data onto `dataOut`, and bounds each tenure with a hold limit. A debounced `toggleButton` press forces an early handover to the next pending requester. It sits between the requester sources and the downstream consumer of `dataOut`, replacing the fixed two-input toggle selection.

## Interface
- `DATA_W`, 9: width of each data word.
- `NUM_REQ`, 4: number of requesters (2..8).
- `MAX_HOLD`, 8: maximum GRANT cycles per tenure while another request is pending (≥2).
- `DEBOUNCE`, 4: consecutive stable cycles required before a button level is accepted (≥1).

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  `NUM_REQ`  request level per requester.
- `dataIn`  in  `NUM_REQ*DATA_W`  requester i's data at `[i*DATA_W +: DATA_W]`.
- `toggleButton`  in  1  raw, asynchronous manual-handover button.
- `grant`  out  `NUM_REQ`  one-hot grant, registered.
- `owner`  out  `$clog2(NUM_REQ)`  index of the current or last owner.
- `dataOut`  out  `DATA_W`  registered data of the current owner.
- `dataValid`  out  1  `dataOut` holds valid owner data.

## Operation
- Reset (`rst`=0): state IDLE; `grant`=0, `owner`=0, `dataOut`=0, `dataValid`=0, `ptr`=0, `hold_cnt`=0; debouncer stable level=0.
- FSM states:
  - **IDLE**: no grant.
  - **GRANT**: one owner holds the mux.
  - **GAP**: one dead cycle between owners; `grant`=0, `dataValid`=0.
- Winner selection: the first set `req[i]`, scanning from `ptr` upward with wrap modulo `NUM_REQ`.
- IDLE or GAP with any `req` set: go to GRANT; `grant[w]`=1, `owner`=w, `hold_cnt`=0. With no `req` set: go to (or stay in) IDLE.
- GRANT with `req[owner]`=1: `dataOut` <= `dataIn[owner]`, `dataValid` <= 1. `hold_cnt` increments and saturates at `MAX_HOLD-1`.
- GRANT exits to GAP on any of the following; on exit `ptr` <= `owner+1` mod `NUM_REQ`, `grant` <= 0, `dataValid` <= 0:
  - `req[owner]`=0;
  - `hold_cnt`==`MAX_HOLD-1` and another requester is pending;
  - `toggle_p`=1 and another requester is pending.
- With no other requester pending, the hold limit and `toggle_p` are ignored and the grant is held indefinitely.
- `dataOut` retains its last value outside GRANT. Only `dataValid` qualifies it.
- `toggle_p` while in IDLE or GAP: ignored and not stored.
- Simultaneous exit causes (request drop plus hold expiry plus toggle): a single GAP cycle.
- A request change by a non-owner during GRANT has no effect until the next arbitration.
- Reset asserted mid-tenure: all outputs clear immediately (asynchronously). After release, requester 0 has first priority.

## Timing
- Request latency: `req` sampled high at edge E0 in IDLE gives `grant` high after E0. `dataValid`=1 with `dataOut`=`dataIn[owner]` sampled at E1 appears after E1.
- Handover: exit condition sampled at edge En gives GAP after En. The next `grant` appears after En+1, and the next `dataValid` after En+2.
- Full-contention tenure: `grant` high for exactly `MAX_HOLD` cycles, followed by 1 GAP cycle.
- Button path: 2-FF synchronizer, then the debounce counter, then rising-edge detect.
  - `toggle_p` is a one-cycle pulse, high in the cycle after edge `DEBOUNCE+2` counted from the first edge that samples the button high.
  - Button pulses shorter than `DEBOUNCE` cycles produce no `toggle_p`.
  - Holding the button produces exactly one pulse.

## Structure
- Shared package/include `mux_pkg`:
  - FSM state encoding `ST_IDLE`=2'd0, `ST_GRANT`=2'd1, `ST_GAP`=2'd2;
  - default `DATA_W`=9;
  - default `NUM_REQ`=4.
- Sub-module `button_debounce`: synchronizer, debounce counter and rising-edge pulse. Parameter `DEBOUNCE`; ports `clk`, `rst`, `btn_in`, `level`, `rise_p`.
- Round-robin pick is a combinational function inside `mux_arbiter`.

## Test plan
- **Reset**: `rst`=0 with `req`=4'b1111 → `grant`=0, `dataOut`=0, `dataValid`=0, `owner`=0. Release → `grant`=4'b0001 after the first edge.
- **Single requester**: `req`=4'b0100, `dataIn[2]`=20 → `grant`=4'b0100 after 1 edge; `dataOut`=20 with `dataValid`=1 after 2 edges. Grant held for more than 20 cycles (no rotation).
- **Full contention**: `req`=4'b1111, `dataIn[i]`=10*(i+1) → owners 0,1,2,3,0. Each has 8 grant cycles, `dataOut`=10/20/30/40, and a 1-cycle GAP with `grant`=0 between owners.
- **Request drop**: `req`=4'b0011; `req[0]` drops on the 3rd grant cycle → GAP at the next edge, then `grant`=4'b0010 and `dataOut`=`dataIn[1]`.
- **Toggle**: `req`=4'b0011, owner 0; button held high 10 cycles → handover to owner 1 before the hold limit, at edge `DEBOUNCE+2`. A 2-cycle button glitch → no handover. Button press with `req`=4'b0001 → grant unchanged.
- **Async reset mid-tenure**: assert `rst` between edges while owner=2 → all outputs 0 immediately. After release with `req`=4'b0101 → requester 0 is granted first.
